// File: rtl/trace_pkg.sv
// trace_pkg: shared types and constants for the light-cycle trace store.
//   cell_t        - grid cell contents (0 = empty, k = owned by player k-1),
//                   sized for the largest legal player count (4).
//   state_t       - game-side FSM states.
//   PAL_*         - 24-bit RGB palette entries.
//   addr_w_f()    - address width for a GRID_W x GRID_H grid.
//   cell_w_f()    - cell width for N players.
//   palette()     - cell contents to RGB.
package trace_pkg;

  localparam int MAX_CELL_W = 3;

  typedef logic [MAX_CELL_W-1:0] cell_t;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RD    = 2'd2,
    ST_EV    = 2'd3
  } state_t;

  localparam logic [23:0] PAL_EMPTY = 24'h000000;
  localparam logic [23:0] PAL_P0    = 24'h0000FF;
  localparam logic [23:0] PAL_P1    = 24'hFF0000;
  localparam logic [23:0] PAL_P2    = 24'h00FF00;
  localparam logic [23:0] PAL_P3    = 24'hFFFF00;

  function automatic int addr_w_f(input int w, input int h);
    return $clog2(w * h);
  endfunction

  function automatic int cell_w_f(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [23:0] palette(input cell_t c);
    case (c)
      3'd1:    return PAL_P0;
      3'd2:    return PAL_P1;
      3'd3:    return PAL_P2;
      3'd4:    return PAL_P3;
      default: return PAL_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/trace_grid_ram.sv
// trace_grid_ram: simple dual-port RAM, synchronous read on both ports,
// no reset on the array so it maps onto block RAM.
//   clk              - clock
//   a_we/a_addr      - game port: write enable / address (read every cycle)
//   a_wdata/a_rdata  - game port write data / registered read data
//   b_addr/b_rdata   - display port: read-only address / registered data
module trace_grid_ram #(
  parameter int DATA_W = 2,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 19200
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Read-first on port A; the game FSM never reads and writes in one cycle.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    a_rdata_q <= mem[a_addr];
    b_rdata_q <= mem[b_addr];
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/trace_grid.sv
// trace_grid: shared occupancy grid for N light-cycle players.
// Each accepted step evaluates every live player's head cell (walls,
// occupied cells, write from the previous evaluation) and writes the trace.
// A second RAM port serves the VGA colour lookup.
//
// Optional feature macro: TRACE_HEADON_EN - when defined, live players whose
// in-bounds targets coincide at step accept are all flagged and none writes.
//
// Ports:
//   clock, reset_n          - clock, asynchronous active-low reset
//   clear_req               - wipe grid and collision flags
//   step_valid/step_ready   - step handshake; pos_x/pos_y latched on accept
//   pos_x, pos_y            - packed 10-bit pixel coords, player 0 in LSBs
//   step_done               - one-cycle pulse when step results are final
//   collided, any_collided  - sticky per-player flags and their OR
//   row, col                - current VGA pixel
//   red, green, blue        - trace colour, valid 1 cycle after row/col
//   dbg_state               - current FSM state (trace_pkg::state_t)
//
// Handshake: a step transfers on a rising edge where step_valid and
// step_ready are both high; step_ready is high only in IDLE with no
// clear_req, and pos_x/pos_y need only be stable in that cycle.
module trace_grid
  import trace_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int GRID_W      = 160,
  parameter int GRID_H      = 120,
  parameter int CELL_SHIFT  = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      clear_req,
  input  logic                      step_valid,
  output logic                      step_ready,
  input  logic [NUM_PLAYERS*10-1:0] pos_x,
  input  logic [NUM_PLAYERS*10-1:0] pos_y,
  output logic                      step_done,
  output logic [NUM_PLAYERS-1:0]    collided,
  output logic                      any_collided,
  input  logic [9:0]                row,
  input  logic [9:0]                col,
  output logic [7:0]                red,
  output logic [7:0]                green,
  output logic [7:0]                blue,
  output logic [1:0]                dbg_state
);

  localparam int          CELL_W  = cell_w_f(NUM_PLAYERS);
  localparam int          ADDR_W  = addr_w_f(GRID_W, GRID_H);
  localparam int          DEPTH   = GRID_W * GRID_H;
  localparam logic [9:0]  GRID_W10 = 10'(GRID_W);
  localparam logic [9:0]  GRID_H10 = 10'(GRID_H);

  function automatic logic [ADDR_W-1:0] lin_addr(input logic [9:0] x, input logic [9:0] y);
    logic [19:0] lin;
    lin = 20'(y) * 20'(GRID_W) + 20'(x);
    return lin[ADDR_W-1:0];
  endfunction

  // Lowest live player index >= start, or NUM_PLAYERS when none is left.
  function automatic logic [2:0] next_live(input logic [NUM_PLAYERS-1:0] dead, input int start);
    logic [2:0] r;
    r = 3'(NUM_PLAYERS);
    for (int j = NUM_PLAYERS - 1; j >= 0; j--)
      if (j >= start && !dead[j]) r = 3'(j);
    return r;
  endfunction

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         clr_addr_q, clr_addr_d;
  logic [NUM_PLAYERS*10-1:0] px_q, px_d, py_q, py_d;
  logic [2:0]                i_q, i_d;
  logic [NUM_PLAYERS-1:0]    collided_q, collided_d;
  logic                      pend_q, pend_d;
  logic                      done_q, done_d;
  logic                      fwd_v_q, fwd_v_d;
  logic [ADDR_W-1:0]         fwd_addr_q, fwd_addr_d;
  logic                      disp_blank_q, disp_blank_d;

  logic                      a_we;
  logic [ADDR_W-1:0]         a_addr, b_addr;
  logic [CELL_W-1:0]         a_wdata, a_rdata, b_rdata;

  logic [9:0]                pcx [NUM_PLAYERS];
  logic [9:0]                pcy [NUM_PLAYERS];
  logic                      p_oob [NUM_PLAYERS];
  logic [ADDR_W-1:0]         p_addr [NUM_PLAYERS];
  logic [ADDR_W-1:0]         cur_addr;
  logic                      cur_oob;
  logic                      hit;
  logic [2:0]                nxt;
  logic [NUM_PLAYERS-1:0]    dead;
  logic [NUM_PLAYERS-1:0]    headon_hit;

  // Cell coordinates of the latched head positions.
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      pcx[p]    = px_q[p*10 +: 10] >> CELL_SHIFT;
      pcy[p]    = py_q[p*10 +: 10] >> CELL_SHIFT;
      p_oob[p]  = (pcx[p] >= GRID_W10) || (pcy[p] >= GRID_H10);
      p_addr[p] = lin_addr(pcx[p], pcy[p]);
    end
  end

  always_comb begin
    cur_addr = '0;
    cur_oob  = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (i_q == 3'(p)) begin
        cur_addr = p_addr[p];
        cur_oob  = p_oob[p];
      end
  end

`ifdef TRACE_HEADON_EN
  logic [9:0] in_cx [NUM_PLAYERS];
  logic [9:0] in_cy [NUM_PLAYERS];
  logic       in_oob [NUM_PLAYERS];

  // Head-on detection on the presented (not yet latched) positions.
  always_comb begin
    headon_hit = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      in_cx[p]  = pos_x[p*10 +: 10] >> CELL_SHIFT;
      in_cy[p]  = pos_y[p*10 +: 10] >> CELL_SHIFT;
      in_oob[p] = (in_cx[p] >= GRID_W10) || (in_cy[p] >= GRID_H10);
    end
    for (int j = 0; j < NUM_PLAYERS; j++)
      for (int k = 0; k < NUM_PLAYERS; k++)
        if (j != k && !collided_q[j] && !collided_q[k] && !in_oob[j] && !in_oob[k] &&
            in_cx[j] == in_cx[k] && in_cy[j] == in_cy[k])
          headon_hit[j] = 1'b1;
  end
`else
  assign headon_hit = '0;
`endif

  // Dead players are skipped by always pointing i_q at the next live
  // player, so a skipped player costs no cycles at all.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    px_d       = px_q;
    py_d       = py_q;
    i_d        = i_q;
    collided_d = collided_q;
    pend_d     = pend_q;
    done_d     = 1'b0;
    fwd_v_d    = fwd_v_q;
    fwd_addr_d = fwd_addr_q;
    a_we       = 1'b0;
    a_addr     = cur_addr;
    a_wdata    = '0;
    step_ready = 1'b0;
    hit        = 1'b0;
    nxt        = 3'(NUM_PLAYERS);
    dead       = collided_q;
    case (state_q)
      ST_CLEAR: begin
        a_we   = 1'b1;
        a_addr = clr_addr_q;
        if (clear_req) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
          clr_addr_d = '0;
          state_d    = ST_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        step_ready = !clear_req;
        if (clear_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          collided_d = '0;
        end else if (step_valid) begin
          px_d       = pos_x;
          py_d       = pos_y;
          fwd_v_d    = 1'b0;
          dead       = collided_q | headon_hit;
          collided_d = dead;
          nxt        = next_live(dead, 0);
          if (nxt < 3'(NUM_PLAYERS)) begin
            i_d     = nxt;
            state_d = ST_RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (clear_req) pend_d = 1'b1;
        state_d = ST_EV;
      end
      ST_EV: begin
        if (clear_req) pend_d = 1'b1;
        hit = cur_oob || (|a_rdata) || (fwd_v_q && fwd_addr_q == cur_addr);
        if (hit) begin
          for (int p = 0; p < NUM_PLAYERS; p++)
            if (i_q == 3'(p)) collided_d[p] = 1'b1;
        end else begin
          a_we       = 1'b1;
          a_wdata    = CELL_W'(i_q + 3'd1);
          fwd_v_d    = 1'b1;
          fwd_addr_d = cur_addr;
        end
        nxt = next_live(collided_q, int'(i_q) + 1);
        if (nxt < 3'(NUM_PLAYERS)) begin
          i_d     = nxt;
          state_d = ST_RD;
        end else begin
          done_d = 1'b1;
          if (pend_q || clear_req) begin
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
            collided_d = '0;
            pend_d     = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Display: address straight from row/col, out-of-grid flag registered
  // alongside the RAM read so both line up one cycle later.
  logic [9:0] dcx, dcy;
  always_comb begin
    dcx          = col >> CELL_SHIFT;
    dcy          = row >> CELL_SHIFT;
    b_addr       = lin_addr(dcx, dcy);
    disp_blank_d = (dcx >= GRID_W10) || (dcy >= GRID_H10);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      px_q         <= '0;
      py_q         <= '0;
      i_q          <= '0;
      collided_q   <= '0;
      pend_q       <= 1'b0;
      done_q       <= 1'b0;
      fwd_v_q      <= 1'b0;
      fwd_addr_q   <= '0;
      disp_blank_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      px_q         <= px_d;
      py_q         <= py_d;
      i_q          <= i_d;
      collided_q   <= collided_d;
      pend_q       <= pend_d;
      done_q       <= done_d;
      fwd_v_q      <= fwd_v_d;
      fwd_addr_q   <= fwd_addr_d;
      disp_blank_q <= disp_blank_d;
    end
  end

  trace_grid_ram #(
    .DATA_W (CELL_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clock),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_rdata (a_rdata),
    .b_addr  (b_addr),
    .b_rdata (b_rdata)
  );

  assign step_done    = done_q;
  assign collided     = collided_q;
  assign any_collided = |collided_q;
  assign dbg_state    = state_q;
  assign {red, green, blue} = disp_blank_q ? 24'h000000 : palette(cell_t'(b_rdata));

endmodule

// File: tb/tb_trace_grid.sv
module tb_trace_grid;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear_req = 1'b0;
  logic        step_valid = 1'b0;
  logic        step_ready;
  logic [19:0] pos_x = '0;
  logic [19:0] pos_y = '0;
  logic        step_done;
  logic [1:0]  collided;
  logic        any_collided;
  logic [9:0]  row = '0;
  logic [9:0]  col = '0;
  logic [7:0]  red, green, blue;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] BLACK = 24'h000000;

  typedef struct {
    logic [9:0] x0, y0, x1, y1;
    int         lat;
    logic [1:0] coll;
  } step_vec_t;

  typedef struct {
    logic [9:0]  r, c;
    logic [23:0] rgb;
  } pix_vec_t;

  step_vec_t steps[4];
  pix_vec_t  pix[9];

  trace_grid dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear_req    (clear_req),
    .step_valid   (step_valid),
    .step_ready   (step_ready),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .step_done    (step_done),
    .collided     (collided),
    .any_collided (any_collided),
    .row          (row),
    .col          (col),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Driver: wait for the clear sweep to finish, counting cycles.
  task automatic wait_ready(input int exp_cycles, input string tag);
    int cnt = 0;
    while (!step_ready && cnt < 25000) begin
      @(posedge clock); #1;
      cnt++;
    end
    chk({tag, "_ready"}, 32'(step_ready), 32'd1);
    chk({tag, "_clear_lat"}, 32'(cnt), 32'(exp_cycles));
  endtask

  task automatic clear_idle(input string tag);
    @(negedge clock);
    clear_req = 1'b1;
    @(posedge clock); #1;
    clear_req = 1'b0;
    chk({tag, "_coll_zero"}, 32'(collided), 32'd0);
    wait_ready(19200, tag);
  endtask

  // Driver: present one step, count cycles (accept cycle = 1) until step_done.
  task automatic run_step(input logic [9:0] x0, input logic [9:0] y0,
                          input logic [9:0] x1, input logic [9:0] y1,
                          input int exp_lat, input logic [1:0] exp_coll,
                          input bit pulse_clear, input string tag);
    int lat;
    bit seen;
    @(negedge clock);
    pos_x = {x1, x0};
    pos_y = {y1, y0};
    step_valid = 1'b1;
    chk({tag, "_ready"}, 32'(step_ready), 32'd1);
    @(posedge clock); #1;
    step_valid = 1'b0;
    lat = 1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (step_done) begin
        seen = 1;
        break;
      end
      if (pulse_clear && k == 0) clear_req = 1'b1;
      @(posedge clock); #1;
      clear_req = 1'b0;
      lat++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_collided"}, 32'(collided), 32'(exp_coll));
    chk({tag, "_any"}, 32'(any_collided), 32'(|exp_coll));
    @(posedge clock); #1;
    chk({tag, "_done_pulse"}, 32'(step_done), 32'd0);
  endtask

  task automatic chk_pix(input logic [9:0] r, input logic [9:0] c, input logic [23:0] exp, input string tag);
    @(negedge clock);
    row = r;
    col = c;
    @(posedge clock); #1;
    chk(tag, {8'd0, red, green, blue}, {8'd0, exp});
  endtask

  initial begin
    // Vectors for the third game: cells are pixel >> 2.
    steps[0] = '{x0: 10'd40,  y0: 10'd40, x1: 10'd80, y1: 10'd40, lat: 5, coll: 2'b00};
    steps[1] = '{x0: 10'd640, y0: 10'd40, x1: 10'd84, y1: 10'd40, lat: 5, coll: 2'b01}; // p0 hits wall
    steps[2] = '{x0: 10'd44,  y0: 10'd40, x1: 10'd88, y1: 10'd40, lat: 3, coll: 2'b01}; // p0 skipped
    steps[3] = '{x0: 10'd0,   y0: 10'd0,  x1: 10'd40, y1: 10'd40, lat: 3, coll: 2'b11}; // p1 onto p0 trace
    pix[0] = '{r: 10'd40,  c: 10'd40,  rgb: BLUE};
    pix[1] = '{r: 10'd40,  c: 10'd43,  rgb: BLUE};
    pix[2] = '{r: 10'd40,  c: 10'd80,  rgb: RED};
    pix[3] = '{r: 10'd40,  c: 10'd84,  rgb: RED};
    pix[4] = '{r: 10'd40,  c: 10'd88,  rgb: RED};
    pix[5] = '{r: 10'd40,  c: 10'd44,  rgb: BLACK};
    pix[6] = '{r: 10'd40,  c: 10'd639, rgb: BLACK};
    pix[7] = '{r: 10'd480, c: 10'd40,  rgb: BLACK};
    pix[8] = '{r: 10'd40,  c: 10'd700, rgb: BLACK};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_step_ready", 32'(step_ready), 32'd0);
    chk("rst_step_done", 32'(step_done), 32'd0);
    chk("rst_collided", 32'(collided), 32'd0);
    chk("rst_any", 32'(any_collided), 32'd0);
    chk("rst_rgb", {8'd0, red, green, blue}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_ready(19200, "boot");
    chk("boot_collided", 32'(collided), 32'd0);
    chk_pix(10'd40, 10'd40, BLACK, "boot_pix_a");
    chk_pix(10'd479, 10'd639, BLACK, "boot_pix_b");

    // Game 1: basic step, then a clear requested mid-step.
    run_step(10'd40, 10'd40, 10'd400, 10'd40, 5, 2'b00, 1'b0, "g1_a");
    chk_pix(10'd40, 10'd40, BLUE, "g1_blue");
    chk_pix(10'd40, 10'd400, RED, "g1_red");
    run_step(10'd48, 10'd40, 10'd404, 10'd40, 5, 2'b00, 1'b1, "g1_midclr");
    // The pulse check inside run_step already spent one sweep cycle.
    wait_ready(19199, "g1_clr");
    chk("g1_clr_coll", 32'(collided), 32'd0);
    chk_pix(10'd40, 10'd40, BLACK, "g1_clr_pix_a");
    chk_pix(10'd40, 10'd48, BLACK, "g1_clr_pix_b");
    chk_pix(10'd40, 10'd400, BLACK, "g1_clr_pix_c");

    // Game 2: both players aim at the same empty cell (50,50).
`ifdef TRACE_HEADON_EN
    run_step(10'd200, 10'd200, 10'd200, 10'd200, 1, 2'b11, 1'b0, "g2_headon");
    chk_pix(10'd200, 10'd200, BLACK, "g2_headon_pix");
`else
    run_step(10'd200, 10'd200, 10'd200, 10'd200, 5, 2'b10, 1'b0, "g2_headon");
    chk_pix(10'd200, 10'd200, BLUE, "g2_headon_pix");
`endif
    clear_idle("g2_clr");
    chk_pix(10'd200, 10'd200, BLACK, "g2_clr_pix");

    // Game 3: table-driven steps, then a display sweep.
    for (int v = 0; v < 4; v++)
      run_step(steps[v].x0, steps[v].y0, steps[v].x1, steps[v].y1,
               steps[v].lat, steps[v].coll, 1'b0, $sformatf("g3_step%0d", v));
    for (int v = 0; v < 9; v++)
      chk_pix(pix[v].r, pix[v].c, pix[v].rgb, $sformatf("g3_pix%0d", v));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
